hazard_forward_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 20 ++
 rtl/fwd_compare.sv | 38 +++
 rtl/hazard_forward_unit.sv | 78 +++++++
 tb/tb_hazard_forward_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared select encodings and pipeline slot type for hazard_forward_unit
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_compare.sv
// rtl/fwd_compare.sv - one operand's forwarding select and load-hit from the EX and MEM slots
module fwd_compare
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic              id_valid,
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    output logic [1:0]        sel,
    output logic              load_hit
);

    logic ex_hit;
    logic mem_hit;
    logic unused_mem_memread;

    assign ex_hit  = ex_slot.valid & ex_slot.regwrite & (ex_slot.rd != '0) &
                     (ex_slot.rd == src) & use_src & id_valid;
    assign mem_hit = mem_slot.valid & mem_slot.regwrite & (mem_slot.rd != '0) &
                     (mem_slot.rd == src) & use_src & id_valid;

    // The MEM slot's load flag is irrelevant here: its data is already available at WB.
    assign unused_mem_memread = mem_slot.memread;

    assign load_hit = ex_hit & ex_slot.memread;

    // Newest producer wins when both slots write the same register.
    always_comb begin
        sel = FWD_REG;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX/MEM destination tracking, registered operand forwarding selects and load-use stall
module hazard_forward_unit #(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter int SEL_W  = hazard_pkg::SEL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o
);
    import hazard_pkg::*;

    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      ex_next;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_a;
    logic       load_b;

    fwd_compare u_cmp_rs1 (
        .src      (id_rs1_i),
        .use_src  (id_use_rs1_i),
        .id_valid (id_valid_i),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_a),
        .load_hit (load_a)
    );

    fwd_compare u_cmp_rs2 (
        .src      (id_rs2_i),
        .use_src  (id_use_rs2_i),
        .id_valid (id_valid_i),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_b),
        .load_hit (load_b)
    );

    // A flush kills the ID instruction outright, so it also suppresses its stall.
    assign stall_o = (load_a | load_b) & ~flush_i;

    always_comb begin
        ex_next = SLOT_BUBBLE;
        if (id_valid_i && !stall_o && !flush_i) begin
            ex_next.valid    = 1'b1;
            ex_next.rd       = id_rd_i;
            ex_next.regwrite = id_regwrite_i;
            ex_next.memread  = id_memread_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_slot  <= SLOT_BUBBLE;
            mem_slot <= SLOT_BUBBLE;
            fwd_a_o  <= FWD_REG;
            fwd_b_o  <= FWD_REG;
        end else begin
            ex_slot  <= ex_next;
            mem_slot <= ex_slot;
            fwd_a_o  <= (stall_o || flush_i) ? FWD_REG : sel_a;
            fwd_b_o  <= (stall_o || flush_i) ? FWD_REG : sel_b;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit with directed instruction sequences
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;
    logic       stall_o;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];
    bit         driving_done = 0;

    hazard_forward_unit dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input bit rst, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input bit u1, input bit u2, input logic [4:0] rd, input bit rw,
                              input bit mr, input bit fl);
        rst_i         = rst;
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_use_rs1_i  = u1;
        id_use_rs2_i  = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
    endtask

    // One cycle: apply ID inputs after the edge and queue the outputs expected at this cycle's midpoint.
    task automatic row(input string nm, input bit rst, input bit v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2, input logic [4:0] rd,
                       input bit rw, input bit mr, input bit fl,
                       input bit es, input logic [1:0] ea, input logic [1:0] eb);
        @(posedge clk);
        #1;
        set_inputs(rst, v, rs1, rs2, u1, u2, rd, rw, mr, fl);
        exp_q.push_back({es, ea, eb});
        name_q.push_back(nm);
    endtask

    task automatic nop(input string nm, input bit es, input logic [1:0] ea, input logic [1:0] eb);
        row(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ea, eb);
    endtask

    initial begin : monitor
        logic [4:0] e;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests_run++;
                if (stall_o !== e[4]) begin
                    tests_failed++;
                    $display("FAIL %s stall: got %b expected %b", nm, stall_o, e[4]);
                end
                tests_run++;
                if (fwd_a_o !== e[3:2]) begin
                    tests_failed++;
                    $display("FAIL %s fwd_a: got %b expected %b", nm, fwd_a_o, e[3:2]);
                end
                tests_run++;
                if (fwd_b_o !== e[1:0]) begin
                    tests_failed++;
                    $display("FAIL %s fwd_b: got %b expected %b", nm, fwd_b_o, e[1:0]);
                end
            end
        end
    end

    initial begin : driver
        set_inputs(0, 1, 5, 5, 1, 1, 5, 1, 0, 0);
        //   name            rst v rs1 rs2 u1 u2 rd rw mr fl   stall a   b
        row("reset1",        0, 1, 5,  5,  1, 1, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        row("reset_release", 1, 1, 5,  5,  1, 1, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("drain1", 0, 2'b00, 2'b00);
        nop("drain2", 0, 2'b00, 2'b00);
        row("add5_1_2",      1, 1, 1,  2,  1, 1, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        row("sub6_5_3",      1, 1, 5,  3,  1, 1, 6, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("sub_in_ex",     0, 2'b10, 2'b00);
        row("add5_again",    1, 1, 1,  2,  1, 1, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("gap",           0, 2'b00, 2'b00);
        row("or7_3_5",       1, 1, 3,  5,  1, 1, 7, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("or_in_ex",      0, 2'b00, 2'b01);
        row("add5_third",    1, 1, 1,  2,  1, 1, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        row("addi5_1",       1, 1, 1,  0,  1, 0, 5, 1, 0, 0,   0, 2'b00, 2'b00);
        row("sub8_5_5",      1, 1, 5,  5,  1, 1, 8, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("newest_wins",   0, 2'b10, 2'b10);
        nop("drain3",        0, 2'b00, 2'b00);
        row("lw6",           1, 1, 1,  0,  1, 0, 6, 1, 1, 0,   0, 2'b00, 2'b00);
        row("add7_stall",    1, 1, 6,  6,  1, 1, 7, 1, 0, 0,   1, 2'b00, 2'b00);
        row("add7_held",     1, 1, 6,  6,  1, 1, 7, 1, 0, 0,   0, 2'b00, 2'b00);
        row("sub9_6_6",      1, 1, 6,  6,  1, 1, 9, 1, 0, 0,   0, 2'b01, 2'b01);
        nop("second_dep_ex", 0, 2'b00, 2'b00);
        row("addi_x0",       1, 1, 0,  0,  1, 0, 0, 1, 0, 0,   0, 2'b00, 2'b00);
        row("add9_0_0",      1, 1, 0,  0,  1, 1, 9, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("x0_in_ex",      0, 2'b00, 2'b00);
        nop("drain4",        0, 2'b00, 2'b00);
        row("lw6_b",         1, 1, 1,  0,  1, 0, 6, 1, 1, 0,   0, 2'b00, 2'b00);
        row("add7_flush",    1, 1, 6,  6,  1, 1, 7, 1, 0, 1,   0, 2'b00, 2'b00);
        row("add10_7_7",     1, 1, 7,  7,  1, 1, 10, 1, 0, 0,  0, 2'b00, 2'b00);
        nop("flush_bubble",  0, 2'b00, 2'b00);
        row("lw6_c",         1, 1, 1,  0,  1, 0, 6, 1, 1, 0,   0, 2'b00, 2'b00);
        row("stall_rst",     0, 1, 6,  6,  1, 1, 7, 1, 0, 0,   1, 2'b00, 2'b00);
        row("after_rst",     1, 1, 6,  6,  1, 1, 7, 1, 0, 0,   0, 2'b00, 2'b00);
        nop("rst_cleared",   0, 2'b00, 2'b00);
        driving_done = 1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(driving_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        tests_run++;
        if (exp_q.size() != 0 || !driving_done) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
